// File: rtl/psum_gather.sv
`default_nettype none
// psum_gather: round-robin collection of tag-locked PE column results into a
// first-word-fall-through FIFO that drains over a valid/ready stream.
module psum_gather #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               flush,
  input  logic [NUM_COL-1:0]                 tag_locks,
  input  logic [NUM_COL-1:0]                 pe_valid,
  input  logic [NUM_COL-1:0][DATA_WIDTH-1:0] pe_data,
  output logic [NUM_COL-1:0]                 pe_ack,
  output logic                               out_valid,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic [$clog2(NUM_COL):0]           out_tag,
  input  logic                               out_ready,
  output logic [$clog2(FIFO_DEPTH):0]        count,
  output logic                               busy
);
  localparam int ARB_W = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
  localparam int TAG_W = $clog2(NUM_COL) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ARB_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
  logic [TAG_W-1:0]      mem_tag_q  [FIFO_DEPTH];

  logic [NUM_COL-1:0]    req;
  logic                  grant_found;
  logic [ARB_W-1:0]      grant_idx;
  logic [ARB_W:0]        scan;
  logic                  push, pop;

  assign req = pe_valid & tag_locks;

  // Scan columns ptr, ptr+1, ... modulo NUM_COL; the first eligible one wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan        = '0;
    for (int k = 0; k < NUM_COL; k++) begin
      scan = {1'b0, ptr_q} + (ARB_W+1)'(k);
      if (scan >= (ARB_W+1)'(NUM_COL)) begin
        scan = scan - (ARB_W+1)'(NUM_COL);
      end
      if (!grant_found && req[scan[ARB_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan[ARB_W-1:0];
      end
    end
  end

  // A same-cycle pop never frees a slot for the push.
  assign push = grant_found && (cnt_q < CNT_W'(FIFO_DEPTH)) && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    pe_ack = '0;
    if (push) begin
      pe_ack[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    if (push) begin
      wr_d  = wr_q + PTR_W'(1);
      ptr_d = (grant_idx == ARB_W'(NUM_COL - 1)) ? '0 : grant_idx + ARB_W'(1);
    end
    if (pop) begin
      rd_d = rd_q + PTR_W'(1);
    end
    if (flush) begin
      ptr_d = '0;
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_tag_q[i]  <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push) begin
        mem_data_q[wr_q] <= pe_data[grant_idx];
        mem_tag_q[wr_q]  <= TAG_W'(grant_idx);
      end
    end
  end

  assign count     = cnt_q;
  assign out_valid = (cnt_q != '0);
  assign out_data  = mem_data_q[rd_q];
  assign out_tag   = mem_tag_q[rd_q];
  assign busy      = (cnt_q != '0) || (req != '0);

endmodule
`default_nettype wire

// File: tb/tb_psum_gather.sv
`default_nettype none
// tb_psum_gather: directed stimulus with a queue-based reference model checked every cycle.
module tb_psum_gather;
  localparam int DATA_WIDTH = 16;
  localparam int NUM_COL    = 10;
  localparam int FIFO_DEPTH = 4;

  logic                               clk;
  logic                               rstn;
  logic                               flush;
  logic [NUM_COL-1:0]                 tag_locks;
  logic [NUM_COL-1:0]                 pe_valid;
  logic [NUM_COL-1:0][DATA_WIDTH-1:0] pe_data;
  logic [NUM_COL-1:0]                 pe_ack;
  logic                               out_valid;
  logic [DATA_WIDTH-1:0]              out_data;
  logic [$clog2(NUM_COL):0]           out_tag;
  logic                               out_ready;
  logic [$clog2(FIFO_DEPTH):0]        count;
  logic                               busy;

  int tests = 0;
  int fails = 0;

  psum_gather #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_COL   (NUM_COL),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (flush),
    .tag_locks(tag_locks),
    .pe_valid (pe_valid),
    .pe_data  (pe_data),
    .pe_ack   (pe_ack),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_tag  (out_tag),
    .out_ready(out_ready),
    .count    (count),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_valid(input logic [NUM_COL-1:0] v, input int base);
    pe_valid = v;
    for (int i = 0; i < NUM_COL; i++) pe_data[i] = DATA_WIDTH'(base + i);
  endtask

  // Reference model: FIFO as queues, arbiter as "first requester at or after
  // the column following the last grant".
  int                 m_tag[$];
  int                 m_data[$];
  int                 m_ptr;
  int                 m_g;
  logic [NUM_COL-1:0] m_req;
  logic [NUM_COL-1:0] m_ack;
  bit                 m_push, m_pop;

  initial begin
    m_ptr = 0;
    forever begin
      @(negedge clk);
      m_push = 1'b0;
      m_pop  = 1'b0;
      m_g    = -1;
      m_req  = pe_valid & tag_locks;
      if (!rstn) begin
        m_tag.delete();
        m_data.delete();
        m_ptr = 0;
        chk("m_rst_ack",   32'(pe_ack),    32'd0);
        chk("m_rst_valid", 32'(out_valid), 32'd0);
        chk("m_rst_count", 32'(count),     32'd0);
        chk("m_rst_busy",  32'(busy),      32'(m_req != '0));
      end else begin
        for (int k = 0; k < NUM_COL; k++) begin
          if (m_g < 0 && m_req[(m_ptr + k) % NUM_COL]) m_g = (m_ptr + k) % NUM_COL;
        end
        m_push = (m_g >= 0) && (m_tag.size() < FIFO_DEPTH) && !flush;
        m_pop  = (m_tag.size() != 0) && out_ready && !flush;
        m_ack  = '0;
        if (m_push) m_ack[m_g] = 1'b1;
        chk("m_ack",   32'(pe_ack),    32'(m_ack));
        chk("m_valid", 32'(out_valid), 32'(m_tag.size() != 0));
        chk("m_count", 32'(count),     32'(m_tag.size()));
        chk("m_busy",  32'(busy),      32'((m_tag.size() != 0) || (m_req != '0)));
        if (m_tag.size() != 0) begin
          chk("m_tag",  32'(out_tag),  32'(m_tag[0]));
          chk("m_data", 32'(out_data), 32'(m_data[0]));
        end
      end
      @(posedge clk);
      if (!rstn || flush) begin
        m_tag.delete();
        m_data.delete();
        m_ptr = 0;
      end else begin
        if (m_pop) begin
          void'(m_tag.pop_front());
          void'(m_data.pop_front());
        end
        if (m_push) begin
          m_tag.push_back(m_g);
          m_data.push_back(int'(pe_data[m_g]));
          m_ptr = (m_g == NUM_COL - 1) ? 0 : m_g + 1;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int bp_ack[4];

  initial begin
    bp_ack[0] = 8; bp_ack[1] = 32; bp_ack[2] = 128; bp_ack[3] = 8;
    rstn = 1'b0; flush = 1'b0; tag_locks = '0; pe_valid = '0; pe_data = '0; out_ready = 1'b0;
    #30;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count),     32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_ack",   32'(pe_ack),    32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_tag",   32'(out_tag),   32'd0);
    rstn = 1'b1;
    tick(); tick();

    // Round-robin over all columns, one word per cycle in and out.
    tag_locks = '1; out_ready = 1'b1;
    set_valid('1, 100);
    for (int c = 0; c <= NUM_COL; c++) begin
      @(negedge clk);
      chk("rr_ack", 32'(pe_ack), 32'(1) << (c % NUM_COL));
      if (c > 0) begin
        chk("rr_tag",  32'(out_tag),  32'((c - 1) % NUM_COL));
        chk("rr_data", 32'(out_data), 32'(100 + (c - 1) % NUM_COL));
        chk("rr_count", 32'(count), 32'd1);
      end
      tick();
    end
    pe_valid = '0;
    tick(); tick();

    // Only columns 0 and 2 unlocked; ptr sits at 1 so column 2 goes first.
    tag_locks = 10'b0000000101;
    set_valid('1, 300);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("mask_ack", 32'(pe_ack), (c % 2 == 0) ? 32'd4 : 32'd1);
      tick();
    end
    pe_valid = '0;
    tick(); tick();

    // Backpressure until full, then release.
    tag_locks = '1; out_ready = 1'b0;
    set_valid(10'b0010101000, 200);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_ack", 32'(pe_ack), 32'(bp_ack[c]));
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("full_count", 32'(count),  32'd4);
      chk("full_ack",   32'(pe_ack), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("rel0_ack", 32'(pe_ack), 32'd0);
    chk("rel0_tag", 32'(out_tag), 32'd3);
    chk("rel0_data", 32'(out_data), 32'd203);
    tick();
    @(negedge clk);
    chk("rel1_count", 32'(count), 32'd3);
    chk("rel1_ack", 32'(pe_ack), 32'd32);
    chk("rel1_tag", 32'(out_tag), 32'd5);
    tick();
    @(negedge clk);
    chk("rel2_count", 32'(count), 32'd3);
    chk("rel2_ack", 32'(pe_ack), 32'd128);
    chk("rel2_tag", 32'(out_tag), 32'd7);
    tick();

    // Flush with three words stored and requests active.
    flush = 1'b1;
    @(negedge clk);
    chk("flush_ack", 32'(pe_ack), 32'd0);
    chk("flush_count", 32'(count), 32'd3);
    tick();
    flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("postflush_count", 32'(count), 32'd0);
    chk("postflush_valid", 32'(out_valid), 32'd0);
    chk("postflush_ack", 32'(pe_ack), 32'd8);
    tick();
    @(negedge clk);
    chk("fill_ack", 32'(pe_ack), 32'd32);
    tick();
    pe_valid = '0;
    @(negedge clk);
    chk("pre_arst_count", 32'(count), 32'd2);

    // Asynchronous reset between clock edges.
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    @(posedge clk);
    #3;
    rstn = 1'b1;
    set_valid(10'b0010100000, 400);
    @(negedge clk);
    chk("arst_first_ack", 32'(pe_ack), 32'd32);
    tick(); tick();
    out_ready = 1'b1;
    repeat (4) tick();
    pe_valid = '0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
